// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key and streams round keys
// 0..10 over a valid/ready handshake, one per accepted transfer.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last round key / index
// EMIT  | presenting round key rnd; advance on each rk_ready
module aes128_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  // Forward S-box, byte 0x00 in the top 8 bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~a selects the byte counted from the top of the table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word, sub_word, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_word[8*i +: 8] = sbox(rot_word[8*i +: 8]);
  end

  assign t_word   = sub_word ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Next-state and register updates for the load / emit / stall cases.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          key_d   = key_in;
          rnd_d   = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rnd_q == 4'd10) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d  = next_key;
            rnd_d  = rnd_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign round_key = key_q;
  assign round_idx = rnd_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Bench for aes128_key_expand: reference key schedule with an S-box built
// from GF(2^8) inversion, a scoreboard of expected round keys, and a table
// of published round-key vectors.
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  aes128_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .rk_ready(rk_ready), .rk_valid(rk_valid), .round_key(round_key),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[7];
  logic [7:0]   sb[256];
  logic [127:0] obs[11];

  int pass_cnt = 0;
  int total_cnt = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  bit rdy_mode = 1'b0;

  bit           exp_done = 1'b0;
  bit           stall_prev = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3r, t, a, b, c, d;
    w3r = {k[23:0], k[31:24]};
    t = {sb[w3r[31:24]], sb[w3r[23:16]], sb[w3r[15:8]], sb[w3r[7:0]]} ^ {rc, 24'h0};
    a = k[127:96] ^ t;
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = k[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  task automatic push_expected(input logic [127:0] key);
    logic [127:0] k = key;
    logic [7:0]   rc = 8'h01;
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.key = k;
      e.idx = 4'(i);
      sb_q.push_back(e);
      k  = model_next(k, rc);
      rc = xt(rc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance.
  task automatic start_key(input logic [127:0] key);
    for (int i = 0; i <= 10; i++) obs[i] = 'x;
    valid_cnt = 0;
    start  = 1'b1;
    key_in = key;
    push_expected(key);
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_to_done(input string name, input int bound, output int cyc);
    cyc = 1;
    for (int i = 0; i < bound; i++) begin
      if (done) return;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk({name, "_timeout"}, 128'(cyc), 128'(bound));
  endtask

  task automatic check_vectors(input logic [127:0] key, input string name);
    for (int i = 0; i < 7; i++)
      if (vecs[i].key == key)
        chk($sformatf("%s_idx%0d", name, vecs[i].idx), obs[vecs[i].idx], vecs[i].rk);
  endtask

  // Ready pattern: continuous or ~50% random, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (rdy_mode) rk_ready = 1'($urandom_range(0, 1));
    else          rk_ready = 1'b1;
  end

  // Scoreboard, stall stability and done-pulse monitor.
  always @(negedge clk) begin
    if (rst) begin
      exp_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("done_pulse", 128'(done), 128'(exp_done));
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("stall_key", round_key, prev_key);
        chk("stall_idx", 128'(round_idx), 128'(prev_idx));
        chk("stall_valid", 128'(rk_valid), 128'(1'b1));
      end
      if (rk_valid) valid_cnt++;
      exp_done = 1'b0;
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_valid: got idx %0d key %h required no valid", round_idx, round_key);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("rk_idx%0d", e.idx), round_key, e.key);
          chk("round_idx", 128'(round_idx), 128'(e.idx));
          if (round_idx <= 4'd10) obs[round_idx] = round_key;
        end
        if (round_idx == 4'd10) exp_done = 1'b1;
      end
      stall_prev = rk_valid && !rk_ready;
      prev_key   = round_key;
      prev_idx   = round_idx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    int spins;

    vecs[0] = '{KEY_A1,   0,  KEY_A1};
    vecs[1] = '{KEY_A1,   1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{KEY_A1,   2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{KEY_A1,   10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{KEY_ZERO, 0,  KEY_ZERO};
    vecs[5] = '{KEY_ZERO, 1,  128'h62636363626363636263636362636363};
    vecs[6] = '{KEY_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_sbox();

    rst = 1'b1; start = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy",  128'(busy),     128'(0));
    chk("rst_done",  128'(done),     128'(0));
    chk("rst_key",   round_key,      128'(0));
    chk("rst_idx",   128'(round_idx), 128'(0));
    @(posedge clk); #1;

    // FIPS-197 A.1 with continuous ready
    start_key(KEY_A1);
    chk("a1_first_valid", 128'(rk_valid), 128'(1));
    chk("a1_first_idx", 128'(round_idx), 128'(0));
    run_to_done("a1", 40, cyc);
    chk("a1_done_cycle", 128'(cyc), 128'(12));
    chk("a1_done_busy", 128'(busy), 128'(0));
    chk("a1_done_valid", 128'(rk_valid), 128'(0));
    chk("a1_valid_cycles", 128'(valid_cnt), 128'(11));
    check_vectors(KEY_A1, "a1");
    chk("a1_queue_empty", 128'(sb_q.size()), 128'(0));
    repeat (2) @(posedge clk); #1;

    // Random backpressure
    rdy_mode = 1'b1;
    d0 = done_cnt;
    start_key(KEY_A1);
    run_to_done("bp", 400, cyc);
    @(negedge clk);
    @(posedge clk); #1;
    rdy_mode = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("bp_done_count", 128'(done_cnt - d0), 128'(1));
    check_vectors(KEY_A1, "bp");
    chk("bp_queue_empty", 128'(sb_q.size()), 128'(0));

    // Zero key
    start_key(KEY_ZERO);
    run_to_done("zero", 40, cyc);
    check_vectors(KEY_ZERO, "zero");
    repeat (2) @(posedge clk); #1;

    // Start while busy: at idx 3 and during the final handshake
    start_key(KEY_A1);
    spins = 0;
    while (!done && spins < 40) begin
      if (rk_valid && (round_idx == 4'd3 || round_idx == 4'd10)) begin
        start  = 1'b1;
        key_in = 128'h00112233445566778899aabbccddeeff;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      spins++;
    end
    start = 1'b0;
    chk("busy_start_done_seen", 128'(done), 128'(1));
    repeat (3) @(posedge clk); #1;
    chk("busy_start_no_valid", 128'(rk_valid), 128'(0));
    chk("busy_start_idle", 128'(busy), 128'(0));
    check_vectors(KEY_A1, "busy_start");
    chk("busy_start_queue", 128'(sb_q.size()), 128'(0));

    // Reset mid-run at idx 5
    start_key(KEY_A1);
    spins = 0;
    while (!(rk_valid && round_idx == 4'd5) && spins < 40) begin
      @(posedge clk); #1;
      spins++;
    end
    chk("rst_mid_reached_idx5", 128'(round_idx), 128'(5));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 128'(rk_valid), 128'(0));
    chk("rst_mid_busy",  128'(busy),     128'(0));
    chk("rst_mid_done",  128'(done),     128'(0));
    chk("rst_mid_key",   round_key,      128'(0));
    chk("rst_mid_idx",   128'(round_idx), 128'(0));
    sb_q.delete();
    repeat (3) @(posedge clk); #1;
    start_key(KEY_A1);
    run_to_done("rst_rerun", 40, cyc);
    chk("rst_rerun_cycle", 128'(cyc), 128'(12));
    check_vectors(KEY_A1, "rst_rerun");

    // Back-to-back: new start in the done cycle
    start_key(KEY_ZERO);
    chk("b2b_first_valid", 128'(rk_valid), 128'(1));
    chk("b2b_first_idx", 128'(round_idx), 128'(0));
    chk("b2b_first_key", round_key, KEY_ZERO);
    run_to_done("b2b", 40, cyc);
    check_vectors(KEY_ZERO, "b2b");
    repeat (3) @(posedge clk); #1;
    chk("final_queue_empty", 128'(sb_q.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key-schedule engine. It accepts a 128-bit cipher key and emits the 11 round keys (round 0 through round 10) one per handshake on a valid/ready interface, for the round datapath downstream. It is the direct consumer of the byte S-box: four S-box instances implement SubWord on the rotated last word of the current round key. Each next round key is computed combinationally from the registered current key, so the engine sustains one round key per cycle under continuous ready.

## Interface
- No parameters. AES-128 only; the widths are fixed.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Reset; synchronous, active-high.
- start  in  1  Request expansion of key_in. Sampled only in IDLE.
- key_in  in  128  Cipher key. w0 = key_in[127:96], w3 = key_in[31:0].
- rk_ready  in  1  Consumer accepts round_key this cycle.
- rk_valid  out  1  round_key / round_idx are valid.
- round_key  out  128  Current round key, same word ordering as key_in.
- round_idx  out  4  Index 0..10 of round_key.
- busy  out  1  High whenever the state is not IDLE.
- done  out  1  One-cycle pulse after round key 10 is accepted.

## Operation
- States:
  - IDLE: rk_valid=0, busy=0.
  - EMIT: rk_valid=1, busy=1.
- IDLE & start → EMIT:
  - key_reg ← key_in, rnd ← 0, rcon ← 8'h01.
- EMIT & rk_ready & rnd<10:
  - key_reg ← next_key, rnd ← rnd+1.
  - rcon ← xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1b,36.
- EMIT & rk_ready & rnd==10 → IDLE; done=1 in the following cycle.
- EMIT & !rk_ready: hold all registers and outputs unchanged (stall), for any length.
- next_key computation:
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- Outputs:
  - round_key = key_reg; round_idx = rnd.
  - In IDLE, round_key and round_idx hold their last values.
- start while busy is ignored; no queuing.
- key_in is sampled only on the accepting edge; later changes have no effect.
- rst has priority over every other input on the same edge:
  - state=IDLE; rnd=0; key_reg=0; rcon=8'h01; done=0.
  - Outputs read rk_valid=0, busy=0, done=0, round_key=0, round_idx=0.
  - Reset mid-expansion aborts it; done is not pulsed.

## Timing
- Start accepted at edge N → rk_valid=1 with round_idx=0 from cycle N+1.
- Each handshake (rk_valid & rk_ready at an edge) advances round_idx by one on that same edge.
- Continuous rk_ready:
  - Keys 0..10 appear in cycles N+1..N+11.
  - done=1 in cycle N+12, with busy=0 and rk_valid=0.
  - A new start is accepted at the edge ending cycle N+12.
- done is registered and lasts exactly one cycle. It coincides with the first IDLE cycle.
- start in the same cycle as the final handshake is ignored, because state is EMIT.
- Combinational path: key_reg → 4× S-box → XOR chain → key_reg. No output depends combinationally on any input.

## Test plan
- FIPS-197 A.1, rk_ready held high. Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c, one-cycle start. Required:
  - idx0 = key_in.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx2 = f2c295f27a96b9435935807a7359f67f.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done one cycle after idx10, exactly 11 valid cycles.
- Backpressure. Stimulus: same key, rk_ready driven by a random ~50% pattern. Required:
  - Identical key sequence.
  - round_key and round_idx stable throughout every stall.
  - done pulses exactly once.
- Zero key. Stimulus: key_in=0. Required:
  - idx1 = 62636363626363636263636362636363.
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start while busy. Stimulus: assert start with a different key_in at idx 3 and at the final-handshake cycle. Required: sequence unaffected, no extra rk_valid.
- Reset mid-run. Stimulus: rst at idx 5 with rk_ready=1. Required:
  - Next cycle rk_valid=0, busy=0, done=0, round_key=0, round_idx=0.
  - A following start produces the correct full A.1 sequence, so rcon was restored.
- Back-to-back. Stimulus: second start issued in the done cycle with the zero key. Required: accepted, with rk_valid and idx0=0 in the next cycle.
